kws_decision: RTL

KWS_DECISION -- requirements
Module: kws_decision

---
 rtl/kws_decision.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/kws_decision.sv
// Keyword-spotting decision stage: serial argmax over an 8-class softmax frame,
// then a per-class streak counter that fires one detection after HOLD_FRAMES hits.
module kws_decision #(
  parameter logic signed [15:0] THRESH      = 16'sd16384,
  parameter int unsigned        HOLD_FRAMES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] prob_0,
  input  logic signed [15:0] prob_1,
  input  logic signed [15:0] prob_2,
  input  logic signed [15:0] prob_3,
  input  logic signed [15:0] prob_4,
  input  logic signed [15:0] prob_5,
  input  logic signed [15:0] prob_6,
  input  logic signed [15:0] prob_7,
  output logic               frame_valid,
  output logic [2:0]         frame_class,
  output logic [15:0]        frame_conf,
  output logic               det_valid,
  output logic [2:0]         det_class
);

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;

  localparam logic [3:0] HOLD = 4'(HOLD_FRAMES);

  state_t             state_q, state_d;
  logic signed [15:0] prob_in [8];
  logic signed [15:0] probs_q [8];
  logic signed [15:0] probs_d [8];
  logic [2:0]         idx_q, idx_d;
  logic [2:0]         best_q, best_d;
  logic signed [15:0] max_q, max_d;
  logic [2:0]         prev_cand_q, prev_cand_d;
  logic [3:0]         streak_q, streak_d;
  logic               frame_valid_q, frame_valid_d;
  logic [2:0]         frame_class_q, frame_class_d;
  logic signed [15:0] frame_conf_q, frame_conf_d;
  logic               det_valid_q, det_valid_d;
  logic [2:0]         det_class_q, det_class_d;
  logic signed [15:0] cur_clamped;
  logic               restart;

  assign prob_in[0] = prob_0;
  assign prob_in[1] = prob_1;
  assign prob_in[2] = prob_2;
  assign prob_in[3] = prob_3;
  assign prob_in[4] = prob_4;
  assign prob_in[5] = prob_5;
  assign prob_in[6] = prob_6;
  assign prob_in[7] = prob_7;

  assign cur_clamped = probs_q[idx_q][15] ? 16'sd0 : probs_q[idx_q];

  always_comb begin
    state_d       = state_q;
    for (int i = 0; i < 8; i++) probs_d[i] = probs_q[i];
    idx_d         = idx_q;
    best_d        = best_q;
    max_d         = max_q;
    prev_cand_d   = prev_cand_q;
    streak_d      = streak_q;
    frame_valid_d = 1'b0;
    frame_class_d = frame_class_q;
    frame_conf_d  = frame_conf_q;
    det_valid_d   = 1'b0;
    det_class_d   = det_class_q;
    restart       = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < 8; i++) probs_d[i] = prob_in[i];
          idx_d   = 3'd0;
          best_d  = 3'd0;
          max_d   = 16'sd0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Strictly-greater keeps the lowest index on ties.
        if (cur_clamped > max_q) begin
          max_d  = cur_clamped;
          best_d = idx_q;
        end
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = DECIDE;
      end
      DECIDE: begin
        state_d       = IDLE;
        frame_valid_d = 1'b1;
        frame_class_d = best_q;
        frame_conf_d  = max_q;
        if (max_q >= THRESH) begin
          if (best_q == prev_cand_q && streak_q != 4'd0) begin
            if (streak_q != 4'd15) streak_d = streak_q + 4'd1;
          end else begin
            restart     = 1'b1;
            streak_d    = 4'd1;
            prev_cand_d = best_q;
          end
          // A saturated or already-fired streak must not re-fire.
          if (streak_d == HOLD && (restart || streak_q != HOLD)) begin
            det_valid_d = 1'b1;
            det_class_d = best_q;
          end
        end else begin
          streak_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      for (int i = 0; i < 8; i++) probs_q[i] <= 16'sd0;
      idx_q         <= 3'd0;
      best_q        <= 3'd0;
      max_q         <= 16'sd0;
      prev_cand_q   <= 3'd0;
      streak_q      <= 4'd0;
      frame_valid_q <= 1'b0;
      frame_class_q <= 3'd0;
      frame_conf_q  <= 16'sd0;
      det_valid_q   <= 1'b0;
      det_class_q   <= 3'd0;
    end else begin
      state_q       <= state_d;
      for (int i = 0; i < 8; i++) probs_q[i] <= probs_d[i];
      idx_q         <= idx_d;
      best_q        <= best_d;
      max_q         <= max_d;
      prev_cand_q   <= prev_cand_d;
      streak_q      <= streak_d;
      frame_valid_q <= frame_valid_d;
      frame_class_q <= frame_class_d;
      frame_conf_q  <= frame_conf_d;
      det_valid_q   <= det_valid_d;
      det_class_q   <= det_class_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign frame_valid = frame_valid_q;
  assign frame_class = frame_class_q;
  assign frame_conf  = frame_conf_q;
  assign det_valid   = det_valid_q;
  assign det_class   = det_class_q;

endmodule
